// File: rtl/opcode_pkg.sv
// Shared types and helpers for the opcode sweep decoder.
// Sizes are bounded by the widest legal selector.
package opcode_pkg;

  localparam int MAX_SEL_W = 6;
  localparam int MAX_OUT_W = 1 << MAX_SEL_W;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  function automatic logic [MAX_OUT_W-1:0] onehot(
    input logic [MAX_SEL_W-1:0] sel
  );
    return MAX_OUT_W'(1) << sel;
  endfunction

  function automatic bit params_ok(
    input int sel_w,
    input int hold
  );
    return (sel_w >= 1) && (sel_w <= MAX_SEL_W) && (hold >= 1);
  endfunction

endpackage

// File: rtl/opcode_sweep_decoder_if.sv
// Selector/opcode bundle between select logic and the decoder.
// master drives selectors and controls, slave returns opcodes.
interface opcode_sweep_decoder_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_W = 1 << SEL_W;

  logic             mode;
  logic             sel_valid;
  logic             sel_ready;
  logic [SEL_W-1:0] sel;
  logic             start;
  logic             abort;
  logic [OUT_W-1:0] op_code;
  logic             op_valid;
  logic [SEL_W-1:0] cur_sel;
  logic             busy;
  logic             done;

  modport master (
    output mode, sel_valid, sel, start, abort,
    input  sel_ready, op_code, op_valid, cur_sel, busy, done
  );

  modport slave (
    input  mode, sel_valid, sel, start, abort,
    output sel_ready, op_code, op_valid, cur_sel, busy, done
  );

endinterface

// File: rtl/opcode_onehot.sv
// Combinational selector to one-hot decoder.
// Drives the opcode register input.
module opcode_onehot
  import opcode_pkg::*;
#(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0]      sel_i,
  output logic [(1<<SEL_W)-1:0] oh_o
);
  localparam int OUT_W = 1 << SEL_W;

  assign oh_o = OUT_W'(onehot(MAX_SEL_W'(sel_i)));

endmodule

// File: rtl/opcode_sweep_decoder.sv
// Registered one-hot opcode decoder with a self-timed
// ascending sweep mode for bring-up stimulus.
module opcode_sweep_decoder
  import opcode_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int HOLD  = 3
) (
  input logic                   clk,
  input logic                   rst,
  opcode_sweep_decoder_if.slave bus
);
  localparam int OUT_W = 1 << SEL_W;
  localparam int HCW   = $clog2(HOLD + 1);
  localparam logic [HCW-1:0]   HOLD_C = HCW'(HOLD);
  localparam logic [SEL_W-1:0] LAST   = SEL_W'(OUT_W - 1);

  if (!params_ok(SEL_W, HOLD)) begin : g_bad_params
    $error("opcode_sweep_decoder: SEL_W must be 1..6, HOLD >= 1");
  end

  state_e           state_q;
  logic [OUT_W-1:0] op_code_q;
  logic             op_valid_q;
  logic [SEL_W-1:0] cur_sel_q;
  logic             busy_q;
  logic             done_q;
  logic [HCW-1:0]   hold_q;

  logic [SEL_W-1:0] dec_sel;
  logic [OUT_W-1:0] dec_oh;

  // One decoder serves direct loads, sweep start and sweep steps.
  always_comb begin
    dec_sel = bus.sel;
    if (state_q == SWEEP) begin
      dec_sel = cur_sel_q + SEL_W'(1);
    end else if (bus.mode) begin
      dec_sel = '0;
    end
  end

  opcode_onehot #(
    .SEL_W(SEL_W)
  ) u_dec (
    .sel_i(dec_sel),
    .oh_o (dec_oh)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      op_code_q  <= '0;
      op_valid_q <= 1'b0;
      cur_sel_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hold_q     <= '0;
    end else begin
      op_valid_q <= 1'b0;
      done_q     <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (bus.mode && bus.start) begin
            state_q    <= SWEEP;
            busy_q     <= 1'b1;
            op_code_q  <= dec_oh;
            cur_sel_q  <= '0;
            hold_q     <= HCW'(1);
            op_valid_q <= 1'b1;
          end else if (!bus.mode && bus.sel_valid) begin
            op_code_q  <= dec_oh;
            cur_sel_q  <= bus.sel;
            op_valid_q <= 1'b1;
          end
        end
        SWEEP: begin
          // Abort outranks a simultaneous final-hold expiry.
          if (bus.abort) begin
            state_q   <= IDLE;
            busy_q    <= 1'b0;
            op_code_q <= '0;
            cur_sel_q <= '0;
            hold_q    <= '0;
          end else if (hold_q == HOLD_C) begin
            if (cur_sel_q == LAST) begin
              state_q   <= IDLE;
              busy_q    <= 1'b0;
              op_code_q <= '0;
              cur_sel_q <= '0;
              hold_q    <= '0;
              done_q    <= 1'b1;
            end else begin
              op_code_q  <= dec_oh;
              cur_sel_q  <= dec_sel;
              hold_q     <= HCW'(1);
              op_valid_q <= 1'b1;
            end
          end else begin
            hold_q <= hold_q + HCW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sel_ready = (state_q == IDLE) && !bus.mode;
  assign bus.op_code   = op_code_q;
  assign bus.op_valid  = op_valid_q;
  assign bus.cur_sel   = cur_sel_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule

// File: tb/tb_opcode_sweep_decoder.sv
// Bench for opcode_sweep_decoder: scoreboard of opcode
// pulses plus a cycle model of sweep timing.
module tb_opcode_sweep_decoder;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  opcode_sweep_decoder_if #(.SEL_W(3)) ia ();
  opcode_sweep_decoder_if #(.SEL_W(4)) ib ();

  opcode_sweep_decoder #(
    .SEL_W(3),
    .HOLD (3)
  ) u_dut_a (
    .clk(clk),
    .rst(rst),
    .bus(ia)
  );

  opcode_sweep_decoder #(
    .SEL_W(4),
    .HOLD (1)
  ) u_dut_b (
    .clk(clk),
    .rst(rst),
    .bus(ib)
  );

  typedef struct {
    logic [7:0] code;
    logic [2:0] sel;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(
    input string       tag,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] code, input logic [2:0] sel);
    exp_t e;
    e.code = code;
    e.sel  = sel;
    q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (ia.op_valid === 1'b1) begin
      if (q.size() == 0) begin
        chk("sb_unexpected_valid", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("sb_code", ia.op_code, e.code);
        chk("sb_sel", ia.cur_sel, e.sel);
      end
    end
  end

  task automatic sweep_a(input int abort_at, input int rst_at, input bit noise);
    int   stop;
    int   shown;
    bit   act;
    logic [63:0] code;
    stop = (abort_at != 0) ? abort_at : rst_at;
    ia.mode  = 1'b1;
    ia.start = 1'b1;
    for (int k = 0; k < 8; k++) push(8'(1 << k), 3'(k));
    @(posedge clk);
    #1;
    for (int c = 1; c <= 27; c++) begin
      ia.abort = (c == abort_at);
      rst      = (c == rst_at);
      if (noise && c >= 3 && c <= 6) begin
        ia.start     = 1'b1;
        ia.sel_valid = 1'b1;
        ia.sel       = 3'd2;
        ia.mode      = 1'b0;
      end else begin
        ia.start     = 1'b0;
        ia.sel_valid = 1'b0;
        ia.mode      = 1'b1;
      end
      @(negedge clk);
      act  = (stop == 0 || c <= stop) && c <= 24;
      code = act ? (64'd1 << ((c - 1) / 3)) : 64'd0;
      chk("sw_code", ia.op_code, code);
      chk("sw_sel", ia.cur_sel, act ? 64'((c - 1) / 3) : 64'd0);
      chk("sw_busy", ia.busy, 64'(act));
      chk("sw_valid", ia.op_valid, 64'(act && ((c - 1) % 3 == 0)));
      chk("sw_done", ia.done, 64'(c == 25 && stop == 0));
      chk("sw_ready", ia.sel_ready, 64'd0);
      @(posedge clk);
      #1;
    end
    ia.abort = 1'b0;
    rst      = 1'b0;
    shown = (stop == 0) ? 8 : (((stop > 24 ? 24 : stop) - 1) / 3 + 1);
    chk("sw_sb_left", 64'(q.size()), 64'(8 - shown));
    q.delete();
  endtask

  initial begin
    ia.mode = 1'b0; ia.sel_valid = 1'b0; ia.sel = '0;
    ia.start = 1'b0; ia.abort = 1'b0;
    ib.mode = 1'b0; ib.sel_valid = 1'b0; ib.sel = '0;
    ib.start = 1'b0; ib.abort = 1'b0;

    // reset with random inputs
    rst = 1'b1;
    ia.mode = 1'($urandom); ia.sel_valid = 1'($urandom);
    ia.sel = 3'($urandom); ia.start = 1'($urandom);
    ia.abort = 1'($urandom);
    ib.mode = ia.mode; ib.start = 1'($urandom);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_code", ia.op_code, 64'd0);
    chk("rst_busy", ia.busy, 64'd0);
    chk("rst_done", ia.done, 64'd0);
    chk("rst_valid", ia.op_valid, 64'd0);
    chk("rst_sel", ia.cur_sel, 64'd0);
    chk("rst_ready", ia.sel_ready, 64'(!ia.mode));
    chk("rst_code_b", ib.op_code, 64'd0);
    chk("rst_ready_b", ib.sel_ready, 64'(!ib.mode));
    @(posedge clk);
    #1;
    ia.mode = 1'b0; ia.sel_valid = 1'b0; ia.start = 1'b0;
    ia.abort = 1'b0; ib.mode = 1'b0; ib.start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;

    // direct mode, back-to-back handshakes
    @(posedge clk);
    #1;
    chk("dir_ready", ia.sel_ready, 64'd1);
    ia.sel_valid = 1'b1;
    ia.sel       = 3'd5;
    push(8'h20, 3'd5);
    @(posedge clk);
    #1;
    chk("dir_code5", ia.op_code, 64'h20);
    chk("dir_sel5", ia.cur_sel, 64'd5);
    ia.sel = 3'd0;
    push(8'h01, 3'd0);
    @(posedge clk);
    #1;
    chk("dir_code0", ia.op_code, 64'h01);
    chk("dir_sel0", ia.cur_sel, 64'd0);
    ia.sel_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("dir_hold", ia.op_code, 64'h01);
    chk("dir_nopulse", ia.op_valid, 64'd0);
    chk("dir_sb_left", 64'(q.size()), 64'd0);

    sweep_a(0, 0, 1'b0);
    sweep_a(10, 0, 1'b1);
    sweep_a(24, 0, 1'b0);
    sweep_a(0, 7, 1'b0);
    sweep_a(0, 0, 1'b0);

    // SEL_W=4, HOLD=1 variant
    ib.mode  = 1'b1;
    ib.start = 1'b1;
    @(posedge clk);
    #1;
    ib.start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      @(negedge clk);
      chk("b_code", ib.op_code, (c <= 16) ? (64'd1 << (c - 1)) : 64'd0);
      chk("b_sel", ib.cur_sel, (c <= 16) ? 64'(c - 1) : 64'd0);
      chk("b_valid", ib.op_valid, 64'(c <= 16));
      chk("b_done", ib.done, 64'(c == 17));
      @(posedge clk);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
